// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default widths for the unified memory port arbiter.
package mem_arb_pkg;
    localparam int DEF_ADDRESS_WIDTH  = 32;
    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_TIMEOUT_CYCLES = 64;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_t;
    typedef enum logic {OWN_IF, OWN_DM} owner_t;
endpackage

// File: rtl/wait_timer.sv
// wait_timer: counts cycles spent waiting for a read response; expired at TIMEOUT_CYCLES-1.
module wait_timer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic [TW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= '0;
        else if (i_clear) r_cnt <= '0;
        else if (i_en) r_cnt <= r_cnt + TW'(1);
    end

    assign o_expired = r_cnt == TW'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch (IF) and data (DM) requesters,
// one transaction at a time, with fetch-flush discard and response timeout.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = DEF_ADDRESS_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     if_req,
    input  logic [ADDRESS_WIDTH-1:0] if_addr,
    input  logic                     if_flush,
    output logic                     if_valid,
    output logic [DATA_WIDTH-1:0]    if_rdata,
    input  logic                     dm_req,
    input  logic                     dm_we,
    input  logic [ADDRESS_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0]    dm_wdata,
    output logic                     dm_valid,
    output logic [DATA_WIDTH-1:0]    dm_rdata,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic                     mem_gnt,
    input  logic                     mem_rvalid,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic                     bus_err
);
    arb_state_t               r_state, w_state_nx;
    owner_t                   r_owner, w_owner_nx;
    logic                     r_we, w_we_nx;
    logic [ADDRESS_WIDTH-1:0] r_addr, w_addr_nx;
    logic [DATA_WIDTH-1:0]    r_wdata, w_wdata_nx;
    logic                     r_drop, w_drop_nx;
    logic                     r_if_valid, w_if_valid_nx;
    logic                     r_dm_valid, w_dm_valid_nx;
    logic [DATA_WIDTH-1:0]    r_if_rdata, w_if_rdata_nx;
    logic [DATA_WIDTH-1:0]    r_dm_rdata, w_dm_rdata_nx;
    logic                     r_bus_err, w_bus_err_nx;
    logic                     w_tclr, w_ten, w_expired;
    logic                     w_dm_win, w_if_win, w_if_flush_own;

    wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_tclr),
        .i_en     (w_ten),
        .o_expired(w_expired)
    );

    // A requester still seeing its valid pulse is holding a stale req; mask it.
    assign w_dm_win       = dm_req && !r_dm_valid;
    assign w_if_win       = if_req && !r_if_valid && !w_dm_win;
    assign w_if_flush_own = if_flush && r_owner == OWN_IF;

    always_comb begin
        w_state_nx    = r_state;
        w_owner_nx    = r_owner;
        w_we_nx       = r_we;
        w_addr_nx     = r_addr;
        w_wdata_nx    = r_wdata;
        w_drop_nx     = r_drop;
        w_if_valid_nx = 1'b0;
        w_dm_valid_nx = 1'b0;
        w_if_rdata_nx = r_if_rdata;
        w_dm_rdata_nx = r_dm_rdata;
        w_bus_err_nx  = r_bus_err;
        w_tclr        = 1'b0;
        w_ten         = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_dm_win) begin
                    w_state_nx = ISSUE;
                    w_owner_nx = OWN_DM;
                    w_we_nx    = dm_we;
                    w_addr_nx  = dm_addr;
                    w_wdata_nx = dm_wdata;
                end else if (w_if_win) begin
                    w_state_nx = ISSUE;
                    w_owner_nx = OWN_IF;
                    w_we_nx    = 1'b0;
                    w_addr_nx  = if_addr;
                    w_wdata_nx = '0;
                    w_drop_nx  = if_flush;
                end
            end
            ISSUE: begin
                w_drop_nx = r_drop || w_if_flush_own;
                if (mem_gnt) begin
                    w_state_nx    = r_we ? IDLE : WAIT;
                    w_tclr        = !r_we;
                    w_dm_valid_nx = r_we;
                    w_dm_rdata_nx = r_we ? '0 : r_dm_rdata;
                end
            end
            WAIT: begin
                w_ten     = 1'b1;
                w_drop_nx = r_drop || w_if_flush_own;
                if (mem_rvalid) begin
                    w_state_nx = IDLE;
                    w_drop_nx  = 1'b0;
                    if (r_owner == OWN_DM) begin
                        w_dm_valid_nx = 1'b1;
                        w_dm_rdata_nx = mem_rdata;
                    end else if (!(r_drop || w_if_flush_own)) begin
                        w_if_valid_nx = 1'b1;
                        w_if_rdata_nx = mem_rdata;
                    end
                end else if (w_expired) begin
                    w_state_nx    = IDLE;
                    w_drop_nx     = 1'b0;
                    w_bus_err_nx  = 1'b1;
                    w_dm_valid_nx = r_owner == OWN_DM;
                    w_if_valid_nx = r_owner == OWN_IF;
                    w_dm_rdata_nx = r_owner == OWN_DM ? '0 : r_dm_rdata;
                    w_if_rdata_nx = r_owner == OWN_IF ? '0 : r_if_rdata;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_owner    <= OWN_IF;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_drop     <= 1'b0;
            r_if_valid <= 1'b0;
            r_dm_valid <= 1'b0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
            r_bus_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_owner    <= w_owner_nx;
            r_we       <= w_we_nx;
            r_addr     <= w_addr_nx;
            r_wdata    <= w_wdata_nx;
            r_drop     <= w_drop_nx;
            r_if_valid <= w_if_valid_nx;
            r_dm_valid <= w_dm_valid_nx;
            r_if_rdata <= w_if_rdata_nx;
            r_dm_rdata <= w_dm_rdata_nx;
            r_bus_err  <= w_bus_err_nx;
        end
    end

    assign mem_req   = r_state == ISSUE;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign if_valid  = r_if_valid;
    assign if_rdata  = r_if_rdata;
    assign dm_valid  = r_dm_valid;
    assign dm_rdata  = r_dm_rdata;
    assign bus_err   = r_bus_err;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed, hand-computed checks of arbitration, handshake, flush,
// timeout and async reset behaviour.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, if_flush, if_valid;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_valid;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid, bus_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_valid(if_valid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_valid(dm_valid), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .bus_err(bus_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; if_req = 0; if_addr = 0; if_flush = 0;
        dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        tick(); tick();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_if_valid", if_valid, 0);
        chk("rst_dm_valid", dm_valid, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_bus_err", bus_err, 0);
        rst_n = 1'b1;
        tick();

        // single fetch, zero-wait memory
        if_req = 1; if_addr = 32'h10; mem_gnt = 1;
        tick();
        chk("f1_mem_req", mem_req, 1);
        chk("f1_mem_addr", mem_addr, 32'h10);
        chk("f1_mem_we", mem_we, 0);
        tick();
        chk("f1_wait_req", mem_req, 0);
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0010_0093;
        tick();
        chk("f1_if_valid", if_valid, 1);
        chk("f1_if_rdata", if_rdata, 32'h0010_0093);
        chk("f1_dm_valid", dm_valid, 0);
        mem_rvalid = 0; if_req = 0;
        tick();
        chk("f1_if_valid_off", if_valid, 0);

        // simultaneous requests: DM first, then IF
        dm_req = 1; dm_we = 0; dm_addr = 32'h100; if_req = 1; if_addr = 32'h20; mem_gnt = 1;
        tick();
        chk("pr_dm_addr", mem_addr, 32'h100);
        tick();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hAAAA_5555;
        tick();
        chk("pr_dm_valid", dm_valid, 1);
        chk("pr_dm_rdata", dm_rdata, 32'hAAAA_5555);
        chk("pr_if_valid_lo", if_valid, 0);
        dm_req = 0; mem_rvalid = 0; mem_gnt = 1;
        tick();
        chk("pr_if_issue", mem_req, 1);
        chk("pr_if_addr", mem_addr, 32'h20);
        chk("pr_dm_valid_off", dm_valid, 0);
        tick();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h1234_5678;
        tick();
        chk("pr_if_valid", if_valid, 1);
        chk("pr_if_rdata", if_rdata, 32'h1234_5678);
        chk("pr_dm_valid_lo", dm_valid, 0);
        mem_rvalid = 0; if_req = 0;
        tick();

        // store with grant delayed three cycles
        dm_req = 1; dm_we = 1; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF;
        tick();
        dm_addr = 32'h999; dm_wdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            chk("st_mem_req", mem_req, 1);
            chk("st_mem_we", mem_we, 1);
            chk("st_mem_addr", mem_addr, 32'h200);
            chk("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
            chk("st_dm_valid_lo", dm_valid, 0);
            mem_gnt = (i == 3);
            tick();
        end
        chk("st_dm_valid", dm_valid, 1);
        chk("st_dm_rdata", dm_rdata, 0);
        chk("st_req_off", mem_req, 0);
        mem_gnt = 0; dm_req = 0; dm_we = 0;
        tick();
        chk("st_dm_valid_off", dm_valid, 0);

        // flush while fetch waits; response discarded, next PC served
        if_req = 1; if_addr = 32'h40; mem_gnt = 1;
        tick();
        tick();
        mem_gnt = 0; if_flush = 1;
        tick();
        if_flush = 0; if_addr = 32'h80; mem_rvalid = 1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        chk("fl_if_valid_lo", if_valid, 0);
        chk("fl_if_rdata_keep", if_rdata, 32'h1234_5678);
        mem_rvalid = 0; mem_gnt = 1;
        tick();
        chk("fl_new_addr", mem_addr, 32'h80);
        chk("fl_new_req", mem_req, 1);
        tick();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0BAD_F00D;
        tick();
        chk("fl_if_valid", if_valid, 1);
        chk("fl_if_rdata", if_rdata, 32'h0BAD_F00D);
        mem_rvalid = 0; if_req = 0;
        tick();

        // load with no response: timeout after 8 cycles in WAIT
        dm_req = 1; dm_we = 0; dm_addr = 32'h300; mem_gnt = 1;
        tick();
        tick();
        mem_gnt = 0;
        for (int i = 0; i < 7; i++) tick();
        chk("to_err_early", bus_err, 0);
        chk("to_valid_early", dm_valid, 0);
        tick();
        chk("to_bus_err", bus_err, 1);
        chk("to_dm_valid", dm_valid, 1);
        chk("to_dm_rdata", dm_rdata, 0);
        chk("to_if_valid_lo", if_valid, 0);
        dm_req = 0; mem_rvalid = 1; mem_rdata = 32'h1111_1111;
        tick();
        chk("late_dm_valid", dm_valid, 0);
        chk("late_if_valid", if_valid, 0);
        chk("late_dm_rdata", dm_rdata, 0);
        chk("late_bus_err", bus_err, 1);
        chk("late_mem_req", mem_req, 0);
        mem_rvalid = 0;
        tick();

        // asynchronous reset in the middle of WAIT
        if_req = 1; if_addr = 32'h50; mem_gnt = 1;
        tick();
        tick();
        mem_gnt = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("ar_bus_err", bus_err, 0);
        chk("ar_mem_addr", mem_addr, 0);
        chk("ar_if_rdata", if_rdata, 0);
        chk("ar_mem_req", mem_req, 0);
        tick();
        rst_n = 1'b1; mem_gnt = 1;
        tick();
        chk("ar_issue_addr", mem_addr, 32'h50);
        chk("ar_issue_req", mem_req, 1);
        tick();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0000_600D;
        tick();
        chk("ar_if_valid", if_valid, 1);
        chk("ar_if_rdata", if_rdata, 32'h0000_600D);
        chk("ar_bus_err_clr", bus_err, 0);
        mem_rvalid = 0; if_req = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between two requesters in the 5-stage pipeline:
  - the fetch stage (IF, read-only);
  - the memory stage (DM, lw/sw).
- Arbitrates, issues one transaction at a time over a req/gnt/rvalid memory handshake, and returns registered data and valid pulses to the owner.
- Supports discarding in-flight fetches on pipeline flush (branch/jump redirect).
- Detects and reports response timeouts.

Parameters:
- ADDRESS_WIDTH, 32, width of all address buses
- DATA_WIDTH, 32, width of all data buses
- TIMEOUT_CYCLES, 64, maximum cycles spent in WAIT before a bus error is declared (>=2)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held high until if_valid
- if_addr  in  ADDRESS_WIDTH  fetch address (PC)
- if_flush  in  1  discard current/pending fetch response
- if_valid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  DATA_WIDTH  fetched instruction
- dm_req  in  1  data request; held high until dm_valid
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDRESS_WIDTH  data address
- dm_wdata  in  DATA_WIDTH  store data
- dm_valid  out  1  one-cycle pulse: load data valid / store complete
- dm_rdata  out  DATA_WIDTH  load data (0 for stores)
- mem_req  out  1  request to memory; held until mem_gnt
- mem_we  out  1  write enable to memory
- mem_addr  out  ADDRESS_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_gnt  in  1  memory accepted request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  DATA_WIDTH  read data
- bus_err  out  1  sticky timeout flag, cleared only by reset

Behaviour:
- Reset (rst_n low, async):
  - State IDLE; all outputs 0; latched address/data/owner registers 0.
  - drop flag 0; timer 0; bus_err 0.
- State IDLE:
  - Arbitration is fixed priority, DM over IF: DM is the older instruction, so this avoids deadlock.
  - A requester whose valid output is high this cycle is masked from arbitration.
  - On a winner: latch owner, addr, we (IF: we=0), and wdata; go to ISSUE.
  - drop is set if the winner is IF and if_flush is high in the same cycle.
- State ISSUE:
  - mem_req=1, and mem_we/addr/wdata come from the latched registers; they are stable until gnt.
  - Requests are never withdrawn.
  - On mem_gnt with we=1: go to IDLE, and pulse dm_valid next cycle with dm_rdata=0.
  - On mem_gnt with we=0: go to WAIT and clear the timer.
- State WAIT:
  - mem_req=0; the timer increments each cycle.
  - On mem_rvalid: register mem_rdata into the owner's rdata and go to IDLE. The owner's valid pulses for that IDLE cycle, unless owner=IF and drop=1: then there is no pulse, if_rdata is unchanged, and drop is cleared.
  - If timer reaches TIMEOUT_CYCLES-1 without rvalid:
    - set bus_err and go to IDLE;
    - the owner's valid pulses with rdata=0 so the pipeline does not hang;
    - drop is cleared.
  - A late rvalid arriving in IDLE is ignored.
- if_flush:
  - Sets drop whenever owner=IF and state is ISSUE or WAIT.
  - Flush together with rvalid in the same cycle suppresses that response.
  - Flush with no IF transaction in flight has no effect.
- Latency (zero-wait memory): read = req seen in cycle 0, valid in cycle 3; store = valid in cycle 2.
- Only one transaction is outstanding at any time.
- Valid outputs are never asserted simultaneously.

Decomposition:
- Package mem_arb_pkg:
  - arb_state_t enum {IDLE, ISSUE, WAIT};
  - owner_t enum {OWN_IF, OWN_DM};
  - default-width constants.
- Sub-module wait_timer:
  - clear/enable inputs;
  - expired output at TIMEOUT_CYCLES-1;
  - counter width $clog2(TIMEOUT_CYCLES).

Test Plan:
- Reset then if_req=1, if_addr=0x0000_0010; memory gnt immediate, rvalid 1 cycle after gnt with rdata=0x0010_0093 -> mem_addr=0x10 in cycle 1, if_valid pulse in cycle 3 with if_rdata=0x0010_0093, dm_valid never asserted.
- if_req and dm_req (lw, 0x100) both high in the same cycle -> DM issued first (mem_addr=0x100), dm_valid precedes IF issue, then IF served with mem_addr=PC; valid pulses never overlap.
- sw dm_addr=0x200, dm_wdata=0xDEADBEEF, gnt delayed 3 cycles -> mem_req/mem_we/mem_addr/mem_wdata stable for 4 cycles, dm_valid pulses exactly 1 cycle after gnt, dm_rdata=0.
- Fetch in WAIT, if_flush pulsed, rvalid later with 0xFFFF_FFFF -> no if_valid, if_rdata unchanged; the next if_req (new PC) is served normally.
- Load issued, memory never returns rvalid -> after TIMEOUT_CYCLES in WAIT, bus_err=1 (sticky), dm_valid pulses with dm_rdata=0, state IDLE; a later rvalid is ignored.
- rst_n asserted mid-WAIT -> outputs 0 immediately (async); after release, the first request completes normally and bus_err=0.
